baud_tick_gen: RTL
==================

BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of the counter and divisor.
REQ-002 SHALL have parameter DIV_DEFAULT, default 5207, giving the divisor after reset (period 5208 clk, 9600 Hz at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1 bit, count enable.
REQ-006 SHALL have port restart, input, 1 bit, synchronous phase restart.
REQ-007 SHALL have port div_wr, input, 1 bit, divisor write strobe.
REQ-008 SHALL have port div_in, input, CNT_W bits, new divisor (period = div+1 clk).
REQ-009 SHALL have port sclk, output, 1 bit, registered square wave.
REQ-010 SHALL have port tick, output, 1 bit, one-clk pulse per period.
REQ-011 SHALL have port ovs_tick, output, 1 bit, oversample pulse (see Configuration).
REQ-012 SHALL have port div_cur, output, CNT_W bits, active divisor.

Function
REQ-013 SHALL keep counter cnt counting 0..div_act and wrapping to 0 on each en=1 edge; "wrap" means cnt==div_act with en=1.
REQ-014 SHALL register sclk as 1 when next cnt < half and 0 otherwise, where half = (div_act+1)>>1; for odd periods the high phase is the shorter.
REQ-015 SHALL register tick high for exactly the one cycle after each wrap (cnt==0 following a wrap), and low otherwise.
REQ-016 SHALL capture div_in into a shadow register on div_wr, clamping values below 1 to 1 (minimum period 2).
REQ-017 SHALL copy the shadow to div_act only at a wrap or a restart, so the period never changes mid-period.
REQ-018 SHALL, when div_wr coincides with a wrap or restart, apply the clamped div_in directly.
REQ-019 SHALL, on restart=1, set cnt to 0, sclk to 1, tick to 0, and load div_act; restart has priority over en.
REQ-020 SHALL, with en=0 and restart=0, hold cnt, sclk and div_act, force tick and ovs_tick low, and still accept div_wr.
REQ-021 SHALL drive div_cur equal to div_act at all times.

Reset
REQ-022 SHALL, while rst=0, set cnt=0, sclk=0, tick=0, ovs_tick=0, and set shadow and div_act to DIV_DEFAULT (clamped to at least 1).
REQ-023 SHALL start counting on the first en=1 edge after rst deasserts, with the first wrap after DIV_DEFAULT+1 enabled edges.

Configuration
REQ-024 SHALL, with macro BAUD_TICK_OVS_EN defined, include a sub-counter with ovs_per = max(1, (div_act+1)>>4) that restarts at every wrap or restart.
REQ-025 SHALL, with BAUD_TICK_OVS_EN defined, pulse ovs_tick for one clk each time the sub-counter reaches ovs_per-1, at most 16 pulses per period, suppressing any remainder pulse.
REQ-026 SHALL, without BAUD_TICK_OVS_EN, tie ovs_tick to 0 and synthesise no sub-counter logic.

Structure
REQ-027 SHALL place in a shared package baud_pkg: the OVS factor constant (16), the minimum-divisor constant (1), and DIV_9600_50M = 5207.
REQ-028 SHALL implement the oversample sub-counter as sub-module baud_ovs_cnt, instantiated only under BAUD_TICK_OVS_EN.

Verification
REQ-029 SHALL cover: DIV_DEFAULT=9, en=1 after reset -> tick every 10 clk; sclk high 5 clk, low 5 clk; div_cur=9.
REQ-030 SHALL cover: div_wr with div_in=4 at cnt=3 of a 10-clk period -> current period completes at 10 clk, then period 5 with sclk high 2 and low 3.
REQ-031 SHALL cover: div_wr with div_in=0 -> div_cur=1 after the next wrap, period 2, sclk alternating 1/0, tick every 2 clk.
REQ-032 SHALL cover: restart asserted at cnt=6 -> next cnt=0, sclk=1, no tick that cycle; next tick 10 clk later.
REQ-033 SHALL cover: en low for 7 clk mid-period -> cnt and sclk frozen, no tick or ovs_tick; period resumes with the remaining count.
REQ-034 SHALL cover: with BAUD_TICK_OVS_EN and div=169 (period 170) -> ovs_per=10; 16 ovs_tick per period, none in the final 10 clk; without the macro ovs_tick stays 0.

Source files
------------

// File: rtl/baud_pkg.sv
// Shared constants and types for the baud tick generator.
package baud_pkg;

  localparam int unsigned OVS_FACTOR   = 16;
  localparam int unsigned OVS_SHIFT    = 4;
  localparam int unsigned MIN_DIV      = 1;
  localparam int unsigned DIV_9600_50M = 5207;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_COUNT,
    STEP_WRAP,
    STEP_RESTART
  } step_e;

endpackage

// File: rtl/baud_ovs_cnt.sv
// Oversample sub-counter: pulses every ovs_per enabled clocks, at most
// OVS_FACTOR times per baud period; re-phased on every wrap/restart.
module baud_ovs_cnt
  import baud_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             reload_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             ovs_tick_o
);

  localparam int unsigned PW = CNT_W + 1;

  logic [PW-1:0] ovs_per;
  logic [PW-1:0] sc_q, sc_d;
  logic [4:0]    pc_q, pc_d, pc_base;
  logic          ovs_q, ovs_d;

  always_comb begin
    ovs_per = ({1'b0, div_i} + PW'(1)) >> OVS_SHIFT;
    if (ovs_per == '0) begin
      ovs_per = PW'(1);
    end

    sc_d    = sc_q;
    pc_d    = pc_q;
    pc_base = pc_q;
    ovs_d   = 1'b0;

    if (step_i) begin
      pc_base = reload_i ? 5'd0 : pc_q;
      if (reload_i || (sc_q == ovs_per - PW'(1))) begin
        sc_d = '0;
      end else begin
        sc_d = sc_q + PW'(1);
      end
      // Pulses beyond OVS_FACTOR are the remainder of a non-multiple period.
      ovs_d = (sc_d == ovs_per - PW'(1)) && (pc_base < 5'(OVS_FACTOR));
      pc_d  = pc_base + 5'(ovs_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc_q  <= '0;
      pc_q  <= '0;
      ovs_q <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      pc_q  <= pc_d;
      ovs_q <= ovs_d;
    end
  end

  assign ovs_tick_o = ovs_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Programmable baud tick / square-wave generator with glitch-free divisor
// updates. Optional oversample pulse output enabled by BAUD_TICK_OVS_EN.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned DIV_DEFAULT = DIV_9600_50M
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             div_wr,
  input  logic [CNT_W-1:0] div_in,
  output logic             sclk,
  output logic             tick,
  output logic             ovs_tick,
  output logic [CNT_W-1:0] div_cur
);

  localparam logic [CNT_W-1:0] DIV_RST =
    (DIV_DEFAULT < MIN_DIV) ? CNT_W'(MIN_DIV) : CNT_W'(DIV_DEFAULT);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] v);
    if (v < CNT_W'(MIN_DIV)) begin
      return CNT_W'(MIN_DIV);
    end
    return v;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             sclk_q, sclk_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] div_wr_val;
  logic [CNT_W:0]   half;
  logic             reload;
  step_e            step;

  always_comb begin
    if (restart) begin
      step = STEP_RESTART;
    end else if (!en) begin
      step = STEP_HOLD;
    end else if (cnt_q == div_act_q) begin
      step = STEP_WRAP;
    end else begin
      step = STEP_COUNT;
    end
  end

  assign reload     = (step == STEP_RESTART) || (step == STEP_WRAP);
  assign div_wr_val = clamp_div(div_in);
  assign half       = ({1'b0, div_act_q} + (CNT_W+1)'(1)) >> 1;

  // A write landing on a period boundary bypasses the shadow.
  always_comb begin
    shadow_d  = div_wr ? div_wr_val : shadow_q;
    div_act_d = div_act_q;
    if (reload) begin
      div_act_d = div_wr ? div_wr_val : shadow_q;
    end
  end

  // Period boundary always yields cnt_d == 0, so the old half is safe here.
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    tick_d = 1'b0;
    case (step)
      STEP_RESTART: begin
        cnt_d  = '0;
        sclk_d = 1'b1;
      end
      STEP_WRAP: begin
        cnt_d  = '0;
        sclk_d = 1'b1;
        tick_d = 1'b1;
      end
      STEP_COUNT: begin
        cnt_d  = cnt_q + CNT_W'(1);
        sclk_d = ({1'b0, cnt_d} < half);
      end
      default: begin
        cnt_d  = cnt_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      div_act_q <= DIV_RST;
      shadow_q  <= DIV_RST;
      sclk_q    <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      shadow_q  <= shadow_d;
      sclk_q    <= sclk_d;
      tick_q    <= tick_d;
    end
  end

  assign sclk    = sclk_q;
  assign tick    = tick_q;
  assign div_cur = div_act_q;

`ifdef BAUD_TICK_OVS_EN
  baud_ovs_cnt #(
    .CNT_W (CNT_W)
  ) u_ovs (
    .clk        (clk),
    .rst        (rst),
    .step_i     (step != STEP_HOLD),
    .reload_i   (reload),
    .div_i      (div_act_d),
    .ovs_tick_o (ovs_tick)
  );
`else
  assign ovs_tick = 1'b0;
`endif

endmodule
